// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: load funct3 codes,
// read-pipeline metadata and load size/extract functions.
package dmem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef struct packed {
    logic        err;
    logic [2:0]  funct3;
    logic [1:0]  off;
    logic [31:0] addr;
  } ld_meta_t;

  // Byte count of a load; 0 marks an illegal funct3.
  function automatic logic [2:0] load_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return 3'd1;
      F3_LH, F3_LHU: return 3'd2;
      F3_LW:         return 3'd4;
      default:       return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [31:0] raw;
    raw = word >> {off, 3'b000};
    case (f3)
      F3_LB:   return {{24{raw[7]}}, raw[7:0]};
      F3_LBU:  return {24'h0, raw[7:0]};
      F3_LH:   return {{16{raw[15]}}, raw[15:0]};
      F3_LHU:  return {16'h0, raw[15:0]};
      F3_LW:   return raw;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_ram.sv
// Single-port word RAM with byte enables and registered read; no reset so
// stores commit regardless of the pipeline reset.
module dmem_responder_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the Execute load/store port: alignment and range checks,
// byte-enabled stores, and a fixed-latency load pipeline with error reporting.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write_in,
  input  logic [31:0] mem_write_addr_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [7:0]  mem_write_mask_in,
  input  logic        mem_read_in,
  input  logic [31:0] mem_read_addr_in,
  input  logic [2:0]  funct3_in,
  output logic        load_valid_out,
  output logic [31:0] load_data_out,
  output logic        error_out,
  output logic [31:0] error_addr_out
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  // Store decode
  logic [31:0] st_rel;
  logic [7:0]  st_lanes;
  logic        st_mask_ok, st_ok, st_err;

  assign st_rel     = mem_write_addr_in - BASE_ADDR;
  assign st_lanes   = mem_write_mask_in << mem_write_addr_in[1:0];
  assign st_mask_ok = (mem_write_mask_in == 8'h01) || (mem_write_mask_in == 8'h03) ||
                      (mem_write_mask_in == 8'h0F);
  assign st_ok      = mem_write_in && st_mask_ok && (st_lanes[7:4] == 4'h0) &&
                      ({1'b0, st_rel} < SPAN);
  assign st_err     = mem_write_in && !st_ok;

  // Load decode; a load alongside a store is rejected
  logic [31:0] ld_rel;
  logic [2:0]  ld_size;
  logic        ld_ok;

  assign ld_rel  = mem_read_addr_in - BASE_ADDR;
  assign ld_size = load_size(funct3_in);
  assign ld_ok   = mem_read_in && !mem_write_in && (ld_size != 3'd0) &&
                   (3'(mem_read_addr_in[1:0]) + ld_size <= 3'd4) &&
                   ({1'b0, ld_rel} < SPAN);

  logic [31:0] ram_rdata;

  dmem_responder_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .be    (st_ok ? st_lanes[3:0] : 4'h0),
    .addr  (mem_write_in ? st_rel[AW+1:2] : ld_rel[AW+1:2]),
    .wdata (mem_write_data_in << {mem_write_addr_in[1:0], 3'b000}),
    .rdata (ram_rdata)
  );

  // Read pipeline: stage 1 lines up with the registered RAM output
  logic [READ_LATENCY:1] vld_pipe;
  ld_meta_t              meta_pipe [READ_LATENCY:1];
  ld_meta_t              meta0;

  assign meta0 = '{err: !ld_ok, funct3: funct3_in, off: mem_read_addr_in[1:0],
                   addr: mem_read_addr_in};

  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= mem_read_in;
      for (int k = 2; k <= READ_LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  always_ff @(posedge clk) begin
    meta_pipe[1] <= meta0;
    for (int k = 2; k <= READ_LATENCY; k++) meta_pipe[k] <= meta_pipe[k-1];
  end

  logic [31:0] d1, out_raw;
  assign d1 = meta_pipe[1].err ? 32'h0
                               : load_extract(ram_rdata, meta_pipe[1].off, meta_pipe[1].funct3);

  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign out_raw = d1;
    end else begin : g_delay
      logic [31:0] dq [READ_LATENCY-1:1];
      always_ff @(posedge clk) begin
        dq[1] <= d1;
        for (int k = 2; k < READ_LATENCY; k++) dq[k] <= dq[k-1];
      end
      assign out_raw = dq[READ_LATENCY-1];
    end
  endgenerate

  // Output stage: data and error address hold between events
  logic        st_err_q, ld_err_out;
  logic [31:0] st_addr_q, data_q, eaddr_q;

  assign load_valid_out = vld_pipe[READ_LATENCY];
  assign load_data_out  = load_valid_out ? out_raw : data_q;
  assign ld_err_out     = load_valid_out && meta_pipe[READ_LATENCY].err;
  assign error_out      = ld_err_out || st_err_q;
  assign error_addr_out = ld_err_out ? meta_pipe[READ_LATENCY].addr :
                          st_err_q   ? st_addr_q : eaddr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_err_q  <= 1'b0;
      st_addr_q <= '0;
      data_q    <= '0;
      eaddr_q   <= '0;
    end else begin
      st_err_q  <= st_err;
      st_addr_q <= mem_write_addr_in;
      data_q    <= load_data_out;
      eaddr_q   <= error_addr_out;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: a READ_LATENCY=1 instance for functional vectors and a
// READ_LATENCY=3 instance for pipelining and reset-flush, sharing stimulus.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write_in = 1'b0;
  logic [31:0] mem_write_addr_in = '0;
  logic [31:0] mem_write_data_in = '0;
  logic [7:0]  mem_write_mask_in = '0;
  logic        mem_read_in = 1'b0;
  logic [31:0] mem_read_addr_in = '0;
  logic [2:0]  funct3_in = '0;

  logic        v1, e1, v3, e3;
  logic [31:0] d1, ea1, d3, ea3;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dmem_responder #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .mem_write_in(mem_write_in), .mem_write_addr_in(mem_write_addr_in),
    .mem_write_data_in(mem_write_data_in), .mem_write_mask_in(mem_write_mask_in),
    .mem_read_in(mem_read_in), .mem_read_addr_in(mem_read_addr_in), .funct3_in(funct3_in),
    .load_valid_out(v1), .load_data_out(d1), .error_out(e1), .error_addr_out(ea1)
  );

  dmem_responder #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .mem_write_in(mem_write_in), .mem_write_addr_in(mem_write_addr_in),
    .mem_write_data_in(mem_write_data_in), .mem_write_mask_in(mem_write_mask_in),
    .mem_read_in(mem_read_in), .mem_read_addr_in(mem_read_addr_in), .funct3_in(funct3_in),
    .load_valid_out(v3), .load_data_out(d3), .error_out(e3), .error_addr_out(ea3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [7:0] m);
    mem_write_in = 1'b1; mem_write_addr_in = a; mem_write_data_in = d; mem_write_mask_in = m;
    step();
    mem_write_in = 1'b0;
  endtask

  task automatic ld1(input string tag, input logic [31:0] a, input logic [2:0] f,
                     input logic [31:0] exp_d, input logic exp_e);
    mem_read_in = 1'b1; mem_read_addr_in = a; funct3_in = f;
    step();
    mem_read_in = 1'b0;
    chk({tag, " vld"}, 32'(v1), 32'd1);
    chk({tag, " data"}, d1, exp_d);
    chk({tag, " err"}, 32'(e1), 32'(exp_e));
  endtask

  logic [31:0] pv [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

  initial begin
    step(); step();
    chk("rst vld", 32'(v1), 0);
    chk("rst data", d1, 0);
    chk("rst err", 32'(e1), 0);
    chk("rst eaddr", ea1, 0);
    reset = 1'b0;

    st(32'h10, 32'hDEAD_BEEF, 8'h0F);
    chk("sw err", 32'(e1), 0);
    ld1("lw 10", 32'h10, 3'd2, 32'hDEAD_BEEF, 1'b0);

    st(32'h10, 32'h0, 8'h0F);
    st(32'h13, 32'h1234_5680, 8'h01);
    ld1("lb 13", 32'h13, 3'd0, 32'hFFFF_FF80, 1'b0);
    ld1("lbu 13", 32'h13, 3'd4, 32'h0000_0080, 1'b0);
    ld1("lw 10b", 32'h10, 3'd2, 32'h8000_0000, 1'b0);

    st(32'h20, 32'h0, 8'h0F);
    st(32'h22, 32'h1234_BEEF, 8'h03);
    ld1("lh 22", 32'h22, 3'd1, 32'hFFFF_BEEF, 1'b0);
    ld1("lhu 22", 32'h22, 3'd5, 32'h0000_BEEF, 1'b0);
    ld1("lw 20", 32'h20, 3'd2, 32'hBEEF_0000, 1'b0);

    st(32'h23, 32'h0000_5555, 8'h03);
    chk("sh23 err", 32'(e1), 1);
    chk("sh23 eaddr", ea1, 32'h23);
    ld1("lw 20 kept", 32'h20, 3'd2, 32'hBEEF_0000, 1'b0);
    step();
    chk("idle vld", 32'(v1), 0);
    chk("hold data", d1, 32'hBEEF_0000);
    chk("hold eaddr", ea1, 32'h23);
    ld1("lw 21 mis", 32'h21, 3'd2, 32'h0, 1'b1);
    chk("lw21 eaddr", ea1, 32'h21);

    // store and load in the same cycle
    mem_write_in = 1'b1; mem_write_addr_in = 32'h40; mem_write_data_in = 32'hCAFE_F00D;
    mem_write_mask_in = 8'h0F;
    mem_read_in = 1'b1; mem_read_addr_in = 32'h40; funct3_in = 3'd2;
    step();
    mem_write_in = 1'b0; mem_read_in = 1'b0;
    chk("both vld", 32'(v1), 1);
    chk("both data", d1, 0);
    chk("both err", 32'(e1), 1);
    chk("both eaddr", ea1, 32'h40);
    step();
    chk("both one pulse", 32'(e1), 0);
    ld1("lw 40", 32'h40, 3'd2, 32'hCAFE_F00D, 1'b0);

    ld1("lw oor", 32'h1000, 3'd2, 32'h0, 1'b1);
    chk("oor eaddr", ea1, 32'h1000);
    ld1("bad f3", 32'h0, 3'd3, 32'h0, 1'b1);

    st(32'h50, 32'hAAAA_AAAA, 8'h0F);
    st(32'h50, 32'h0000_0001, 8'h07);
    chk("mask7 err", 32'(e1), 1);
    chk("mask7 eaddr", ea1, 32'h50);
    ld1("lw 50 kept", 32'h50, 3'd2, 32'hAAAA_AAAA, 1'b0);

    // store error and load error report together; load address wins
    mem_write_in = 1'b1; mem_write_addr_in = 32'h63; mem_write_data_in = 32'h1;
    mem_write_mask_in = 8'h03;
    mem_read_in = 1'b1; mem_read_addr_in = 32'h64; funct3_in = 3'd2;
    step();
    mem_write_in = 1'b0; mem_read_in = 1'b0;
    chk("prio err", 32'(e1), 1);
    chk("prio eaddr", ea1, 32'h64);

    reset = 1'b1;
    st(32'h80, 32'h0000_0077, 8'h0F);
    reset = 1'b0;
    ld1("lw 80 rst", 32'h80, 3'd2, 32'h0000_0077, 1'b0);

    // READ_LATENCY=3 back-to-back
    repeat (4) step();
    for (int i = 0; i < 4; i++) st(32'(i * 4), pv[i], 8'h0F);
    for (int i = 0; i < 7; i++) begin
      mem_read_in = (i < 4); mem_read_addr_in = 32'(i * 4); funct3_in = 3'd2;
      step();
      mem_read_in = 1'b0;
      if (i >= 2 && i <= 5) begin
        chk("rl3 vld", 32'(v3), 1);
        chk("rl3 data", d3, pv[i-2]);
      end else if (i == 6) begin
        chk("rl3 tail", 32'(v3), 0);
      end
    end

    // reset flushes in-flight loads
    mem_read_in = 1'b1; mem_read_addr_in = 32'h0; funct3_in = 3'd2;
    step();
    mem_read_addr_in = 32'h4;
    step();
    mem_read_in = 1'b0;
    chk("rl1 out before rst", d1, 32'h2222_2222);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("flush vld", 32'(v3), 0);
      chk("flush err", 32'(e3), 0);
      step();
    end
    chk("flush data", d3, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the Execute stage's load/store request port; the memory end of the interface Execute drives.
- Accepts registered store requests (addr, data, unshifted byte mask) and load requests (addr, funct3).
- Performs byte-lane alignment, misalignment and range checks, and byte-enabled writes into a word RAM.
- Returns load data sign- or zero-extended per funct3 after a fixed, parameterised latency, for the writeback stage.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
- READ_LATENCY, 1, cycles from load request to load_valid_out; legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_write_in  in  1  store request strobe
- mem_write_addr_in  in  32  store byte address
- mem_write_data_in  in  32  store data, LSB-aligned (unshifted)
- mem_write_mask_in  in  8  unshifted byte mask: 1 = SB, 3 = SH, 15 = SW
- mem_read_in  in  1  load request strobe
- mem_read_addr_in  in  32  load byte address
- funct3_in  in  3  load type: 0 = LB, 1 = LH, 2 = LW, 4 = LBU, 5 = LHU
- load_valid_out  out  1  one-cycle pulse; load data valid
- load_data_out  out  32  extended load result
- error_out  out  1  one-cycle pulse; misaligned, out-of-range or illegal request
- error_addr_out  out  32  byte address of the last error; held until the next error

Behaviour:
- Reset: load_valid_out = 0, load_data_out = 0, error_out = 0, error_addr_out = 0. All read-pipeline valid bits cleared; in-flight loads are dropped and never return. RAM contents are not cleared.
- Address decode: off = addr[1:0]; word index = (addr - BASE_ADDR) >> 2.
  - In range iff (addr - BASE_ADDR) < DEPTH_WORDS*4, compared as unsigned 32-bit.
- Store path:
  - lanes[7:0] = mask << off. Misaligned iff lanes[7:4] != 0.
  - Mask values other than 1, 3 or 15 are illegal.
  - Accepted store: RAM word bytes i where lanes[i] = 1 get (data << 8*off) byte i, at the clock edge ending the request cycle. Zero latency; no response.
  - Misaligned, illegal or out-of-range store: no RAM write. Next cycle error_out = 1 and error_addr_out = addr.
- Load path:
  - Size from funct3: 0 or 4 = 1 byte, 1 or 5 = 2 bytes, 2 = 4 bytes. Other funct3 values are illegal.
  - Misaligned iff off + size > 4.
  - Accepted load: RAM read is registered. A pipeline of depth READ_LATENCY carries {valid, funct3, off}.
  - load_valid_out asserts exactly READ_LATENCY cycles after the request cycle.
  - Extraction: raw = word >> 8*off. LB sign-extends raw[7:0]; LBU zero-extends it. LH sign-extends raw[15:0]; LHU zero-extends it. LW passes raw.
  - Misaligned, illegal or out-of-range load: error_out pulses at the same cycle a valid load would return (READ_LATENCY later). load_valid_out = 1 with load_data_out = 0, so writeback stays in lockstep.
- Back-to-back loads: one per cycle, fully pipelined. Responses return in order with no bubbles.
- Store then load to the same word:
  - Store in cycle N, load in cycle N+1 returns the new data. The RAM write commits before the read edge.
  - No forwarding logic is needed.
- Simultaneous mem_write_in and mem_read_in in one cycle is illegal:
  - The store executes.
  - The load is rejected through the error path, with error_addr_out = mem_read_addr_in, and returns 0 with load_valid_out.
  - One error_out pulse per illegal event.
  - If a store error and a load error would report in the same cycle, the load error wins error_addr_out.
- load_data_out holds its last value when load_valid_out = 0.
- Reset asserted in the cycle of a store: the write still commits. Reset gates only the pipeline and output registers.

Decomposition:
- Mem_pkg additions:
  - funct3 load constants LB, LH, LW, LBU, LHU.
  - Size-from-funct3 function.
  - Load-extract function (word, off, funct3) -> 32-bit result.
- dmem_responder keeps alignment/range checks, the read pipeline and error reporting.
- Sub-module dmem_ram:
  - Single-port, DEPTH_WORDS x 32, 4 byte enables, registered read.
  - Write-before-read across cycles, no reset.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 next cycle -> load_valid_out at READ_LATENCY, data 0xDEADBEEF, error_out = 0.
- SB 0x80 @0x13 over word 0x00000000, then LB @0x13 -> 0xFFFFFF80. LBU @0x13 -> 0x00000080. LW @0x10 -> 0x80000000.
- SH 0xBEEF @0x22, LH @0x22 -> 0xFFFFBEEF. LHU @0x22 -> 0x0000BEEF.
- SH @0x23 -> no write (LW @0x20 unchanged), error_out pulse, error_addr_out = 0x23. LW @0x21 -> load_valid_out with data 0, error_out, error_addr_out = 0x21.
- READ_LATENCY = 3, loads on 4 consecutive cycles to 0x0, 0x4, 0x8, 0xC -> 4 consecutive valid pulses in order. Assert reset for one cycle after the second load -> only the responses already out remain; no further load_valid_out.
- mem_write_in and mem_read_in high in the same cycle at 0x40 -> store committed, load returns 0, one error_out, error_addr_out = 0x40. LW @(BASE_ADDR + DEPTH_WORDS*4) -> error_out, data 0.
